apb_xfer_arbiter: RTL
=====================

// Module: apb_xfer_arbiter
// PURPOSE
//  Shares the single APB bridge command port (transfer/READ_WRITE/paddr/data) between NUM_REQ requesters.
//  Round-robin arbitration; sequences each transfer (setup + held-stable access window), then returns the
//  captured apb_read_data_out/PSLVERR to the winning requester. Sits between the bus agents and the bridge.
// PARAMETERS
//  NUM_REQ   4  number of requesters (2..8)
//  ADDR_W    9  bridge address width (apb_write_paddr/apb_read_paddr)
//  DATA_W    8  bridge data width
//  HOLD_CYC  2  cycles after the setup cycle during which all bridge inputs are held stable (>=1)
// PORTS
//  PCLK              in   1                clock; all logic on posedge
//  PRESETn           in   1                asynchronous, active-low reset
//  req_valid         in   NUM_REQ          per-requester command valid
//  req_rw            in   NUM_REQ          1 = read, 0 = write
//  req_addr          in   NUM_REQ*ADDR_W   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata         in   NUM_REQ*DATA_W   packed write data
//  req_ready         out  NUM_REQ          one-hot accept pulse
//  rsp_valid         out  NUM_REQ          one-hot response pulse
//  rsp_rdata         out  DATA_W           read data (0 for writes)
//  rsp_err           out  1                captured PSLVERR
//  busy              out  1                high in every non-IDLE state
//  transfer          out  1                bridge transfer request
//  READ_WRITE        out  1                bridge direction
//  apb_write_paddr   out  ADDR_W           bridge write address
//  apb_write_data    out  DATA_W           bridge write data
//  apb_read_paddr    out  ADDR_W           bridge read address
//  PSLVERR           in   1                bridge slave error
//  apb_read_data_out in   DATA_W           bridge read data
// BEHAVIOUR
//  Reset (async assert, sync deassert use): all outputs 0, state IDLE, rr pointer = NUM_REQ-1 (req 0 wins first).
//  All outputs registered; bridge outputs never X. Unused address/data bus driven 0 (read: write bus 0; write: read addr 0).
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE  : if |req_valid: winner = first set bit searching from ptr+1 upward, wrapping; latch rw/addr/wdata and
//           winner id; req_ready[winner]=1 next cycle (one-cycle pulse); ptr <= winner; go SETUP. Else stay.
//   SETUP : transfer=1, READ_WRITE/addr/data driven from latch; cnt<=0; go ACCESS (1 cycle).
//   ACCESS: transfer=1, all bridge inputs identical to SETUP; cnt++; after HOLD_CYC cycles go RESP.
//   RESP  : transfer=0, bridge buses back to 0; rsp_valid[id]=1 for exactly 1 cycle; rsp_err=PSLVERR and
//           rsp_rdata=(rw ? apb_read_data_out : 0), both sampled on the edge leaving the last ACCESS cycle; go IDLE.
//  Latency (HOLD_CYC=2): accept edge k -> transfer high cycles k+1..k+3 -> rsp_valid at k+4; 1 idle bubble between
//   back-to-back grants, so one transfer per HOLD_CYC+3 cycles max.
//  rsp_rdata/rsp_err hold their value until the next RESP; rsp_valid, req_ready low otherwise.
//  Requester rule: req_valid and payload held until req_ready; req_valid sampled only in IDLE, so a request dropped
//   before grant is simply not served (no error). Payload changes after accept have no effect.
//  Simultaneous: new req_valid during SETUP/ACCESS/RESP waits for IDLE; a requester re-asserting in the RESP cycle is
//   arbitrated in the following IDLE with the pointer already past it (fairness: max NUM_REQ-1 grants of wait).
//  PSLVERR=1 does not abort or retry; it is reported only. X on PSLVERR/read data outside RESP capture is ignored.
//  Reset mid-transfer: transfer and buses drop to 0 immediately, no rsp_valid for the aborted command, ptr reinit.
// STRUCTURE
//  apb_arb_pkg: state_t enum {IDLE,SETUP,ACCESS,RESP}; APB_ADDR_W=9, APB_DATA_W=8 constants; cmd_t struct {rw,addr,wdata}.
//  Sub-module apb_rr_picker (combinational): inputs req vector + ptr, outputs one-hot grant and index; reused by
//   other shared-resource arbiters. FSM, latch, hold counter, response capture live in apb_xfer_arbiter.
// TESTING
//  1. Reset, req_valid[0]=1 write addr 0x012 data 0xA5 -> req_ready[0] next cycle; transfer=1 for 3 cycles with
//     READ_WRITE=0, paddr 0x012, data 0xA5, read addr 0; rsp_valid[0] at accept+4, rsp_err=0, rsp_rdata=0.
//  2. Read req[2] addr 0x1F0, bridge returns 0x3C -> apb_read_paddr stable 3 cycles, write bus 0; rsp_rdata=0x3C.
//  3. All 4 req_valid held high -> grant order 0,1,2,3,0; grants spaced 5 cycles; no requester served twice in a row.
//  4. PSLVERR=1 in last ACCESS cycle of a write -> rsp_err=1 with rsp_valid; next transfer starts normally.
//  5. PRESETn low during ACCESS -> same cycle transfer=0, buses 0; no rsp_valid; after release req 0 wins first.
//  6. Assertions: every transfer window of HOLD_CYC+1 cycles has $stable bridge inputs; no X on bridge outputs ever.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and default bus widths for the APB transfer arbiter and its helpers.
package apb_arb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  rw;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: the first set request above ptr (wrapping) wins.
module apb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Scan ptr+1 .. ptr+N modulo N and keep only the first hit.
  always_comb begin
    logic          found;
    logic          hit;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    hit   = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand        = IW'((int'(ptr) + off) % N);
      hit         = req[cand] & ~found;
      grant[cand] = hit;
      idx         = hit ? cand : idx;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/apb_xfer_arbiter_chk.sv
// Bridge-side properties: inputs stable across each transfer window, window length, no unknowns.
module apb_xfer_arbiter_chk #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input logic              PCLK,
  input logic              PRESETn,
  input logic              transfer,
  input logic              READ_WRITE,
  input logic [ADDR_W-1:0] apb_write_paddr,
  input logic [DATA_W-1:0] apb_write_data,
  input logic [ADDR_W-1:0] apb_read_paddr
);

  logic [2*ADDR_W+DATA_W:0] bus_s;
  logic [7:0]               run_q;

  assign bus_s = {READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr};

  // Length of the current run of transfer-high cycles.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      run_q <= 8'd0;
    end else if (transfer) begin
      run_q <= run_q + 8'd1;
    end else begin
      run_q <= 8'd0;
    end
  end

  a_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (transfer && $past(transfer)) |-> $stable(bus_s));

  a_window: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (!transfer && (run_q != 8'd0)) |-> (run_q == 8'(HOLD_CYC + 1)));

  a_no_x: assert property (@(posedge PCLK) disable iff (!PRESETn)
    !$isunknown({transfer, bus_s}));

endmodule

// File: rtl/apb_xfer_arbiter.sv
// Shares one APB bridge command port between NUM_REQ requesters: round-robin grant,
// setup + held access window, then a one-cycle response carrying the captured read data / PSLVERR.
module apb_xfer_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int HOLD_CYC = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic                      PSLVERR,
  input  logic [DATA_W-1:0]         apb_read_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, id_q, id_d;
  cmd_t                 cmd_q, cmd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic                 xfer_q, xfer_d, rw_q, rw_d;
  logic [ADDR_W-1:0]    wr_paddr_q, wr_paddr_d, rd_paddr_q, rd_paddr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;

  apb_rr_picker #(.N(NUM_REQ), .IW(IDX_W)) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Sequencer: grant/latch in IDLE, hold count in ACCESS, response capture in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = SETUP;
          ptr_d       = pick_idx;
          id_d        = pick_idx;
          cmd_d.rw    = req_rw[pick_idx];
          cmd_d.addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          cmd_d.wdata = req_wdata[pick_idx*DATA_W +: DATA_W];
          req_ready_d = pick_grant;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        rsp_valid_d = ONE_HOT0 << id_q;
        rsp_err_d   = PSLVERR;
        if (cmd_q.rw) begin
          rsp_rdata_d = apb_read_data_out;
        end else begin
          rsp_rdata_d = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bridge drive: only the bus matching the direction carries the latched command.
  always_comb begin
    busy_d     = (state_d != IDLE);
    xfer_d     = (state_q == SETUP) || (state_q == ACCESS);
    rw_d       = 1'b0;
    wr_paddr_d = '0;
    wr_data_d  = '0;
    rd_paddr_d = '0;
    if (xfer_d) begin
      rw_d = cmd_q.rw;
      if (cmd_q.rw) begin
        rd_paddr_d = cmd_q.addr;
      end else begin
        wr_paddr_d = cmd_q.addr;
        wr_data_d  = cmd_q.wdata;
      end
    end else begin
      rw_d = 1'b0;
    end
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      id_q        <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      xfer_q      <= 1'b0;
      rw_q        <= 1'b0;
      wr_paddr_q  <= '0;
      wr_data_q   <= '0;
      rd_paddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      xfer_q      <= xfer_d;
      rw_q        <= rw_d;
      wr_paddr_q  <= wr_paddr_d;
      wr_data_q   <= wr_data_d;
      rd_paddr_q  <= rd_paddr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign busy            = busy_q;
  assign transfer        = xfer_q;
  assign READ_WRITE      = rw_q;
  assign apb_write_paddr = wr_paddr_q;
  assign apb_write_data  = wr_data_q;
  assign apb_read_paddr  = rd_paddr_q;

endmodule
